// File: rtl/outr_serial_tx_if.sv
// ---------------------------------------------------------------------------
// outr_serial_tx_if
//
// Purpose:
//   CPU-side bus between the OUTR register / CPU control logic and the
//   outr_serial_tx peripheral. It bundles the word, the load strobe, the
//   status flags and the overrun clear into one connection.
//
// Signals:
//   outr_data [15:0]  word from the CPU OUTR register
//   out_load          single-cycle pulse: OUTR was loaded, start transmission
//   ovr_clr           synchronous clear of the sticky overrun flag
//   fgo               output flag: 1 = idle and ready, 0 = transmitting
//   ovr               sticky overrun: a load arrived while fgo was 0
//
// Modports:
//   master  CPU side (drives outr_data/out_load/ovr_clr, reads fgo/ovr)
//   slave   peripheral side (reads outr_data/out_load/ovr_clr, drives fgo/ovr)
// ---------------------------------------------------------------------------
interface outr_serial_tx_if;
  logic [15:0] outr_data;
  logic        out_load;
  logic        ovr_clr;
  logic        fgo;
  logic        ovr;

  modport master (
    output outr_data,
    output out_load,
    output ovr_clr,
    input  fgo,
    input  ovr
  );

  modport slave (
    input  outr_data,
    input  out_load,
    input  ovr_clr,
    output fgo,
    output ovr
  );
endinterface

// File: rtl/outr_serial_tx.sv
// ---------------------------------------------------------------------------
// outr_serial_tx
//
// Purpose:
//   Output-side terminal peripheral for the CPU's OUTR register. A 16-bit
//   word captured on out_load is sent on a single serial line as two
//   asynchronous frames, low byte first, with no idle gap between them.
//   A Mano-style FGO flag tells the CPU when the next OUT may be issued, and
//   a sticky OVR flag records loads that arrived while still busy.
//
// Optional feature (macro OUTR_SERIAL_TX_PARITY_EN):
//   undefined : 8N1 frames (start, 8 data, stop), 20 bit periods per word
//   defined   : 8E1 frames (start, 8 data, even parity, stop),
//               22 bit periods per word
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit period (2 .. 65535)
//   DATA_BITS     data bits per frame; fixed at 8 so one word = two frames
//
// Ports:
//   clk     system clock, all state changes on the rising edge
//   reset   asynchronous, active-low reset
//   bus     outr_serial_tx_if.slave (outr_data, out_load, ovr_clr, fgo, ovr)
//   tx      serial line, idles high
// ---------------------------------------------------------------------------
module outr_serial_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  outr_serial_tx_if.slave        bus,
  output logic                   tx
);

  localparam int                BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef OUTR_SERIAL_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [15:0]       holding;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic              byte_idx;
  logic              ovr_q;

  logic              bit_end;
  logic              load_idle;
  logic [7:0]        cur_byte;

  // A bit period ends on the last count of the baud counter; every state
  // transition outside IDLE is gated by this.
  assign bit_end   = (baud_cnt == BAUD_MAX);
  assign load_idle = bus.out_load && (state == IDLE);
  assign cur_byte  = byte_idx ? holding[15:8] : holding[7:0];

  // State register. Reset drops straight to IDLE, which also forces tx high
  // through the output decode, so an aborted frame never emits a partial
  // stop bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. STOP of the low byte loops straight back into START
  // so the two frames of one word are contiguous.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.out_load) begin
          next_state = START;
        end
      end
      START: begin
        if (bit_end) begin
          next_state = DATA;
        end
      end
      DATA: begin
        if (bit_end && (bit_cnt == LAST_BIT)) begin
`ifdef OUTR_SERIAL_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef OUTR_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          next_state = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          next_state = byte_idx ? IDLE : START;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode. The line level and the ready flag are pure functions of
  // the registered state and counters, so they change only after a clock
  // edge (or immediately on reset).
  always_comb begin
    tx      = 1'b1;
    bus.fgo = 1'b0;
    case (state)
      IDLE: begin
        tx      = 1'b1;
        bus.fgo = 1'b1;
      end
      START: begin
        tx = 1'b0;
      end
      DATA: begin
        tx = cur_byte[bit_cnt];
      end
`ifdef OUTR_SERIAL_TX_PARITY_EN
      PARITY: begin
        tx = ^cur_byte;
      end
`endif
      STOP: begin
        tx = 1'b1;
      end
      default: begin
        tx      = 1'b1;
        bus.fgo = 1'b0;
      end
    endcase
  end

  // Baud counter. It free-runs through 0..CLKS_PER_BIT-1 while busy and is
  // held at zero in IDLE so each start bit gets a full period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
    end else if (bit_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + BAUD_W'(1);
    end
  end

  // Bit counter and byte index. The bit counter advances once per data bit
  // period and is re-zeroed at the end of every start bit. The byte index
  // flips to the high byte when the low byte's stop bit finishes; a new load
  // is the only thing that sets it back to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      byte_idx <= 1'b0;
    end else if (load_idle) begin
      bit_cnt  <= '0;
      byte_idx <= 1'b0;
    end else if (bit_end) begin
      case (state)
        START: begin
          bit_cnt <= '0;
        end
        DATA: begin
          bit_cnt <= bit_cnt + 3'd1;
        end
        STOP: begin
          if (!byte_idx) begin
            byte_idx <= 1'b1;
          end
        end
        default: begin
          bit_cnt <= bit_cnt;
        end
      endcase
    end
  end

  // Holding register. outr_data is captured only when a load is accepted in
  // IDLE; loads while busy leave the word being shifted untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      holding <= '0;
    end else if (load_idle) begin
      holding <= bus.outr_data;
    end
  end

  // Sticky overrun flag. A rejected load sets it; the set has priority over
  // a clear arriving in the same cycle so no overrun is ever lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovr_q <= 1'b0;
    end else if (bus.out_load && (state != IDLE)) begin
      ovr_q <= 1'b1;
    end else if (bus.ovr_clr) begin
      ovr_q <= 1'b0;
    end
  end

  assign bus.ovr = ovr_q;

endmodule
